mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Round-robin arbiter that shares one `mem` instance between `NREQ` requesters in the Gaussian-elimination datapath. Read and write ports are arbitrated independently, so one read and one write issue per cycle. Granted reads return tagged data one cycle later, aligned to the memory's registered `q`. It sits between the row-processing units and the `mem` instance and owns all of that memory's `data`, `rdaddress`, `rden`, `wraddress` and `wren` pins.

## Interface
- `WIDTH`, 8, data word width; must match the attached `mem`.
- `DEPTH`, 64, number of words; `AW` = `CLOG2(DEPTH)`.
- `NREQ`, 4, number of requesters, 2..16; `IW` = `CLOG2(NREQ)`.

Ports:
- `clock` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `rd_valid` in NREQ: per-requester read request.
- `rd_addr` in NREQ*AW: packed read addresses; requester i uses bits [i*AW +: AW].
- `rd_ready` out NREQ: one-hot read grant.
- `wr_valid` in NREQ: per-requester write request.
- `wr_addr` in NREQ*AW: packed write addresses.
- `wr_data` in NREQ*WIDTH: packed write data.
- `wr_ready` out NREQ: one-hot write grant.
- `rsp_valid` out 1: read data valid.
- `rsp_id` out IW: requester that owns `rsp_data`.
- `rsp_data` out WIDTH: read data.
- `mem_data`, `mem_wraddress`, `mem_wren`, `mem_rdaddress`, `mem_rden`: outputs driving the `mem` pins of the same names.
- `mem_q` in WIDTH: the `mem` `q` output.

## Operation
- Two independent round-robin arbiters, one for reads and one for writes. Each has a pointer register `rd_ptr` / `wr_ptr` of width IW.
- Search order starts at the pointer and runs ptr, ptr+1, ..., wrapping modulo NREQ. The first requester with valid set is granted.
- After a grant to i, the pointer becomes (i+1) mod NREQ. The pointer holds when there is no grant.
- Grant signals (`rd_ready`, `wr_ready`) are combinational from valid and pointer. A transfer occurs when valid && ready. A requester must hold its address and data until ready is seen.
- Read grant in cycle T: `mem_rden`=1 and `mem_rdaddress`=rd_addr[i]. In T+1, `rsp_valid`=1, `rsp_id`=i, `rsp_data`=`mem_q`.
- Write grant in cycle T: `mem_wren`=1, `mem_wraddress`=wr_addr[j], `mem_data`=wr_data[j]. The memory is updated at the end of T.
- Out-of-range address (≥ DEPTH):
  - The request is still granted and consumed.
  - For a read, `mem_rden`=0 and `rsp_valid`=1 with `rsp_data`=0.
  - For a write, `mem_wren`=0.
- When idle, `mem_rden`/`mem_wren`=0; address and data pins are don't-care.
- A simultaneous read and write to the same address in one cycle returns the old word, unless `MEM_ARB_FORWARD_EN` is defined (see Configuration).
- Back-to-back reads are supported; the response rate is one per cycle.

## Timing
- Reset values: `rd_ptr`=`wr_ptr`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0. Requester 0 has top priority after reset.
- While `reset` is high, all grants, `mem_rden` and `mem_wren` are forced to 0.
- Read latency is exactly 1 cycle from grant to `rsp_valid`. There is no backpressure on the response; requesters must accept it.
- Reset asserted in the cycle after a grant: `rsp_valid`=0 in that cycle and in the next. The in-flight response is dropped.
- `rsp_valid`/`rsp_id` are registered. `rsp_data` is `mem_q`, muxed with the registered forward/zero path.
- Pointer wrap: a grant to NREQ-1 sets the pointer to 0.
- Every continuously asserted requester is granted within NREQ cycles.

## Configuration
- `MEM_ARB_FORWARD_EN` defined:
  - If the read and write granted in the same cycle target the same in-range address, the write data is registered.
  - The next cycle's `rsp_data` returns that new word instead of `mem_q`.
- `MEM_ARB_FORWARD_EN` undefined: no compare logic. The same-cycle, same-address read returns the pre-write contents.

## Test plan
- Reset, then `rd_valid`=4'b1111 held 8 cycles (NREQ=4) -> `rd_ready` sequence 0001,0010,0100,1000,0001,...; `rsp_id` sequence 0,1,2,3,... one cycle delayed.
- Requester 2 writes 8'hA5 to address 5. Next cycle requester 1 reads address 5 -> `rsp_valid` with `rsp_id`=1, `rsp_data`=8'hA5, one cycle after the read grant.
- Memory holds 8'h11 at address 7. Same-cycle write of 8'h22 and read of address 7 -> `rsp_data`=8'h22 with `MEM_ARB_FORWARD_EN`, 8'h11 without it.
- DEPTH=48, read of address 50 -> granted, `mem_rden`=0, `rsp_valid`=1, `rsp_data`=0. A write to address 50 -> `mem_wren`=0; memory unchanged.
- Read granted in cycle T, `reset` high in T+1 -> `rsp_valid`=0 in T+1 and T+2. Pointers return to 0, and requester 0 wins the next contention against requester 3.
- Only requester 3 valid for 5 cycles -> granted every cycle; `rd_ptr` is 0 after each grant.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Requester-side bundle of mem_port_arbiter: read/write
//               request channels, one-hot grants and the tagged read response.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_port_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 64,
    parameter int NREQ  = 4
);
    localparam int AW = $clog2(DEPTH);
    localparam int IW = $clog2(NREQ);

    logic [NREQ-1:0]       rd_valid;
    logic [NREQ*AW-1:0]    rd_addr;
    logic [NREQ-1:0]       rd_ready;
    logic [NREQ-1:0]       wr_valid;
    logic [NREQ*AW-1:0]    wr_addr;
    logic [NREQ*WIDTH-1:0] wr_data;
    logic [NREQ-1:0]       wr_ready;
    logic                  rsp_valid;
    logic [IW-1:0]         rsp_id;
    logic [WIDTH-1:0]      rsp_data;

    modport master (
        output rd_valid, rd_addr, wr_valid, wr_addr, wr_data,
        input  rd_ready, wr_ready, rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  rd_valid, rd_addr, wr_valid, wr_addr, wr_data,
        output rd_ready, wr_ready, rsp_valid, rsp_id, rsp_data
    );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module      : mem_port_arbiter
// Description : Independent round-robin read and write arbiters sharing one
//               registered-output mem; reads answer one cycle after grant.
//               Optional macro MEM_ARB_FORWARD_EN forwards same-cycle
//               same-address write data to the read response.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 64,
    parameter int NREQ  = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int IW   = $clog2(NREQ)
) (
    input  wire logic             clock,
    input  wire logic             reset,
    mem_port_arbiter_if.slave     req,
    output logic [WIDTH-1:0]      mem_data,
    output logic [AW-1:0]         mem_wraddress,
    output logic                  mem_wren,
    output logic [AW-1:0]         mem_rdaddress,
    output logic                  mem_rden,
    input  wire logic [WIDTH-1:0] mem_q
);

    localparam logic [IW:0]   c_nreq  = (IW+1)'(NREQ);
    localparam logic [IW-1:0] c_last  = IW'(NREQ - 1);
    localparam logic [AW:0]   c_depth = (AW+1)'(DEPTH);

    // Returns {found, index}; scanning from the far end lets the requester
    // closest to the pointer overwrite the others.
    function automatic logic [IW:0] f_pick(input logic [NREQ-1:0] valid,
                                           input logic [IW-1:0]   ptr);
        logic [IW:0]   sum;
        logic [IW-1:0] cand;
        logic [IW:0]   res;
        res = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            sum  = {1'b0, ptr} + (IW+1)'(k);
            cand = (sum >= c_nreq) ? IW'(sum - c_nreq) : IW'(sum);
            if (valid[cand]) begin
                res = {1'b1, cand};
            end
        end
        return res;
    endfunction

    function automatic logic [IW-1:0] f_next(input logic [IW-1:0] idx);
        return (idx == c_last) ? '0 : idx + 1'b1;
    endfunction

    logic [IW-1:0]    r_rd_ptr;
    logic [IW-1:0]    r_wr_ptr;
    logic             r_rsp_valid;
    logic [IW-1:0]    r_rsp_id;
    logic             r_rsp_zero;

    logic [IW:0]      w_rd_pick;
    logic [IW:0]      w_wr_pick;
    logic             w_rd_fire;
    logic             w_wr_fire;
    logic [IW-1:0]    w_rd_idx;
    logic [IW-1:0]    w_wr_idx;
    logic [AW-1:0]    w_rd_addr;
    logic [AW-1:0]    w_wr_addr;
    logic [WIDTH-1:0] w_wr_data;
    logic             w_rd_inrange;
    logic             w_wr_inrange;
    logic             w_rsp_valid;

    always_comb begin
        w_rd_pick    = f_pick(req.rd_valid, r_rd_ptr);
        w_wr_pick    = f_pick(req.wr_valid, r_wr_ptr);
        w_rd_idx     = w_rd_pick[IW-1:0];
        w_wr_idx     = w_wr_pick[IW-1:0];
        w_rd_fire    = w_rd_pick[IW] && !reset;
        w_wr_fire    = w_wr_pick[IW] && !reset;
        w_rd_addr    = req.rd_addr[w_rd_idx*AW +: AW];
        w_wr_addr    = req.wr_addr[w_wr_idx*AW +: AW];
        w_wr_data    = req.wr_data[w_wr_idx*WIDTH +: WIDTH];
        w_rd_inrange = ({1'b0, w_rd_addr} < c_depth);
        w_wr_inrange = ({1'b0, w_wr_addr} < c_depth);
    end

    always_comb begin
        req.rd_ready = '0;
        req.wr_ready = '0;
        if (w_rd_fire) begin
            req.rd_ready[w_rd_idx] = 1'b1;
        end
        if (w_wr_fire) begin
            req.wr_ready[w_wr_idx] = 1'b1;
        end
    end

    // Out-of-range requests are consumed but never touch the memory.
    assign mem_rden      = w_rd_fire && w_rd_inrange;
    assign mem_rdaddress = w_rd_addr;
    assign mem_wren      = w_wr_fire && w_wr_inrange;
    assign mem_wraddress = w_wr_addr;
    assign mem_data      = w_wr_data;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_zero  <= 1'b0;
        end else begin
            if (w_rd_fire) begin
                r_rd_ptr <= f_next(w_rd_idx);
                r_rsp_id <= w_rd_idx;
            end
            if (w_wr_fire) begin
                r_wr_ptr <= f_next(w_wr_idx);
            end
            r_rsp_valid <= w_rd_fire;
            r_rsp_zero  <= !w_rd_inrange;
        end
    end

    // Reset in the cycle after a grant must drop the in-flight response.
    assign w_rsp_valid   = r_rsp_valid && !reset;
    assign req.rsp_valid = w_rsp_valid;
    assign req.rsp_id    = r_rsp_id;

`ifdef MEM_ARB_FORWARD_EN
    logic             r_fwd_hit;
    logic [WIDTH-1:0] r_fwd_data;
    logic             w_fwd_hit;

    assign w_fwd_hit = w_rd_fire && w_wr_fire && w_rd_inrange && w_wr_inrange
                       && (w_rd_addr == w_wr_addr);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_fwd_hit  <= 1'b0;
            r_fwd_data <= '0;
        end else begin
            r_fwd_hit  <= w_fwd_hit;
            r_fwd_data <= w_wr_data;
        end
    end

    always_comb begin
        req.rsp_data = '0;
        if (w_rsp_valid && !r_rsp_zero) begin
            req.rsp_data = r_fwd_hit ? r_fwd_data : mem_q;
        end
    end
`else
    always_comb begin
        req.rsp_data = '0;
        if (w_rsp_valid && !r_rsp_zero) begin
            req.rsp_data = mem_q;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed and random stimulus against a grant/memory reference
//               model, with an attached registered-output memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;
    localparam int WIDTH = 8;
    localparam int DEPTH = 48;
    localparam int NREQ  = 4;
    localparam int AW    = 6;
    localparam int IW    = 2;

    logic             clock = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] mem_data;
    logic [AW-1:0]    mem_wraddress;
    logic             mem_wren;
    logic [AW-1:0]    mem_rdaddress;
    logic             mem_rden;
    logic [WIDTH-1:0] mem_q;

    always #5 clock = ~clock;

    mem_port_arbiter_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREQ(NREQ)) bus ();

    mem_port_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREQ(NREQ)) dut (
        .clock         (clock),
        .reset         (reset),
        .req           (bus),
        .mem_data      (mem_data),
        .mem_wraddress (mem_wraddress),
        .mem_wren      (mem_wren),
        .mem_rdaddress (mem_rdaddress),
        .mem_rden      (mem_rden),
        .mem_q         (mem_q)
    );

    // Attached memory: registered q, read-before-write on collisions.
    logic [WIDTH-1:0] env_mem [DEPTH];
    always @(posedge clock) begin
        if (mem_rden && mem_rdaddress < DEPTH) mem_q <= env_mem[mem_rdaddress];
        if (mem_wren && mem_wraddress < DEPTH) env_mem[mem_wraddress] <= mem_data;
    end

    int             n_tests = 0;
    int             n_fail  = 0;
    logic [7:0]     ref_mem [DEPTH];
    int             rptr = 0;
    int             wptr = 0;
    bit             exp_v = 1'b0;
    int             exp_id = 0;
    logic [7:0]     exp_data = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] v, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [23:0] pa(input int a0, input int a1, input int a2, input int a3);
        return {6'(a3), 6'(a2), 6'(a1), 6'(a0)};
    endfunction

    function automatic logic [31:0] pd(input int d0, input int d1, input int d2, input int d3);
        return {8'(d3), 8'(d2), 8'(d1), 8'(d0)};
    endfunction

    task automatic cyc(input logic rst_v, input logic [3:0] rv, input logic [23:0] ra,
                       input logic [3:0] wv, input logic [23:0] wa, input logic [31:0] wd);
        int  gr, gw, ra_i, wa_i;
        bit  r_in, w_in;
        logic [7:0] wd_j;
        @(negedge clock);
        reset        = rst_v;
        bus.rd_valid = rv;
        bus.rd_addr  = ra;
        bus.wr_valid = wv;
        bus.wr_addr  = wa;
        bus.wr_data  = wd;
        #1;
        gr   = rst_v ? -1 : pick(rv, rptr);
        gw   = rst_v ? -1 : pick(wv, wptr);
        ra_i = (gr >= 0) ? int'(ra[gr*AW +: AW]) : 0;
        wa_i = (gw >= 0) ? int'(wa[gw*AW +: AW]) : 0;
        wd_j = (gw >= 0) ? wd[gw*WIDTH +: WIDTH] : 8'h00;
        r_in = (gr >= 0) && (ra_i < DEPTH);
        w_in = (gw >= 0) && (wa_i < DEPTH);

        chk("rd_ready", 32'(bus.rd_ready), (gr >= 0) ? (32'd1 << gr) : 32'd0);
        chk("wr_ready", 32'(bus.wr_ready), (gw >= 0) ? (32'd1 << gw) : 32'd0);
        chk("mem_rden", 32'(mem_rden), 32'(r_in));
        chk("mem_wren", 32'(mem_wren), 32'(w_in));
        if (r_in) chk("mem_rdaddress", 32'(mem_rdaddress), ra_i);
        if (w_in) begin
            chk("mem_wraddress", 32'(mem_wraddress), wa_i);
            chk("mem_data", 32'(mem_data), 32'(wd_j));
        end
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(exp_v && !rst_v));
        if (exp_v && !rst_v) begin
            chk("rsp_id", 32'(bus.rsp_id), exp_id);
            chk("rsp_data", 32'(bus.rsp_data), 32'(exp_data));
        end
        if (!rst_v) begin
            chk("rd_ptr", 32'(dut.r_rd_ptr), rptr);
            chk("wr_ptr", 32'(dut.r_wr_ptr), wptr);
        end

        if (rst_v) begin
            rptr  = 0;
            wptr  = 0;
            exp_v = 1'b0;
        end else begin
            exp_v = (gr >= 0);
            if (gr >= 0) begin
                exp_id   = gr;
                exp_data = r_in ? ref_mem[ra_i] : 8'h00;
`ifdef MEM_ARB_FORWARD_EN
                if (r_in && w_in && ra_i == wa_i) exp_data = wd_j;
`endif
                rptr = (gr + 1) % NREQ;
            end
            if (gw >= 0) begin
                if (w_in) ref_mem[wa_i] = wd_j;
                wptr = (gw + 1) % NREQ;
            end
        end
    endtask

    initial begin
        logic [3:0]  rv, wv;
        logic [23:0] ra, wa;
        logic [31:0] wd;

        reset        = 1'b1;
        bus.rd_valid = '0;
        bus.rd_addr  = '0;
        bus.wr_valid = '0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;

        // Grants and memory enables stay low under reset even with requests.
        cyc(1'b1, 4'hF, '0, 4'hF, '0, '0);
        cyc(1'b1, 4'hF, '0, 4'hF, '0, '0);
        @(posedge clock);
        #1;
        chk("reset_rsp_id", 32'(bus.rsp_id), 32'd0);
        chk("reset_rsp_data", 32'(bus.rsp_data), 32'd0);

        // Fill memory with known contents through the write port.
        for (int i = 0; i < DEPTH; i++) begin
            wv = 4'b0001 << $urandom_range(0, 3);
            cyc(1'b0, 4'h0, '0, wv, pa(i, i, i, i), $urandom);
        end

        // All readers requesting: strict rotation 0,1,2,3,...
        for (int i = 0; i < 8; i++) cyc(1'b0, 4'hF, pa(1, 2, 3, 4), 4'h0, '0, '0);
        cyc(1'b0, 4'h0, '0, 4'h0, '0, '0);

        // Write then read-back of the same word.
        cyc(1'b0, 4'h0, '0, 4'b0100, pa(0, 0, 5, 0), pd(0, 0, 'hA5, 0));
        cyc(1'b0, 4'b0010, pa(0, 5, 0, 0), 4'h0, '0, '0);
        cyc(1'b0, 4'h0, '0, 4'h0, '0, '0);
        chk("readback_A5", 32'(bus.rsp_data), 32'hA5);

        // Same-cycle read and write of one address.
        cyc(1'b0, 4'h0, '0, 4'b0001, pa(7, 0, 0, 0), pd('h11, 0, 0, 0));
        cyc(1'b0, 4'b0010, pa(0, 7, 0, 0), 4'b0001, pa(7, 0, 0, 0), pd('h22, 0, 0, 0));
        cyc(1'b0, 4'h0, '0, 4'h0, '0, '0);
`ifdef MEM_ARB_FORWARD_EN
        chk("collide_rsp", 32'(bus.rsp_data), 32'h22);
`else
        chk("collide_rsp", 32'(bus.rsp_data), 32'h11);
`endif

        // Out-of-range address 50 on both ports.
        cyc(1'b0, 4'b0100, pa(0, 0, 50, 0), 4'b1000, pa(0, 0, 0, 50), pd(0, 0, 0, 'h5A));
        cyc(1'b0, 4'h0, '0, 4'h0, '0, '0);
        chk("oor_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("oor_rsp_data", 32'(bus.rsp_data), 32'd0);

        // Reset right after a read grant drops the response.
        cyc(1'b0, 4'b0100, pa(0, 0, 3, 0), 4'b0100, pa(0, 0, 9, 0), pd(0, 0, 'h3C, 0));
        cyc(1'b1, 4'h0, '0, 4'h0, '0, '0);
        cyc(1'b0, 4'b1001, pa(1, 0, 0, 2), 4'b1001, pa(11, 0, 0, 12), pd('h77, 0, 0, 'h88));
        chk("post_reset_rd_grant", 32'(bus.rd_ready), 32'b0001);
        chk("post_reset_wr_grant", 32'(bus.wr_ready), 32'b0001);

        // Lone requester 3 is granted every cycle; pointer wraps to 0.
        for (int i = 0; i < 5; i++) cyc(1'b0, 4'b1000, pa(0, 0, 0, i), 4'h0, '0, '0);
        cyc(1'b0, 4'h0, '0, 4'h0, '0, '0);

        // Random traffic with address collisions and out-of-range mixed in.
        for (int n = 0; n < 400; n++) begin
            rv = 4'($urandom);
            wv = 4'($urandom);
            for (int k = 0; k < NREQ; k++) begin
                ra[k*AW +: AW] = ($urandom_range(0, 4) == 0) ? 6'($urandom_range(40, 63))
                                                             : 6'($urandom_range(0, 7));
                wa[k*AW +: AW] = ($urandom_range(0, 4) == 0) ? 6'($urandom_range(40, 63))
                                                             : 6'($urandom_range(0, 7));
            end
            wd = $urandom;
            cyc(($urandom_range(0, 59) == 0), rv, ra, wv, wa, wd);
        end
        cyc(1'b0, 4'h0, '0, 4'h0, '0, '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
